// File: rtl/async_fifo_pkg.sv
// Shared types and constants for the async FIFO read-side stream logic.
package async_fifo_pkg;

    // Read-side controller states.
    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } rd_state_t;

    // Output buffer geometry.
    localparam int unsigned BUF_DEPTH    = 2;
    localparam int unsigned BUF_PTR_BITS = 1;
    localparam int unsigned BUF_CNT_BITS = 2;

    localparam logic [BUF_CNT_BITS-1:0] BUF_FULL = BUF_CNT_BITS'(BUF_DEPTH);

    // Slot reached by stepping 'offset' entries past 'base' in the circular
    // buffer. With a power-of-two depth the pointer wraps naturally.
    function automatic logic [BUF_PTR_BITS-1:0] buf_slot(
        input logic [BUF_PTR_BITS-1:0] base,
        input logic [BUF_CNT_BITS-1:0] offset
    );
        return base + offset[BUF_PTR_BITS-1:0];
    endfunction

endpackage

// File: rtl/stream_skid_buf2.sv
// Two-entry circular output buffer: head pointer, occupancy count and
// push/pop bookkeeping for the stream reader.
module stream_skid_buf2
    import async_fifo_pkg::*;
#(
    parameter int unsigned DATA_BITS = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    push,
    input  logic [DATA_BITS-1:0]    push_data,
    input  logic                    pop,
    output logic [DATA_BITS-1:0]    head_data,
    output logic [BUF_CNT_BITS-1:0] cnt
);

    logic [DATA_BITS-1:0]    entry_q [BUF_DEPTH];
    logic [DATA_BITS-1:0]    entry_d [BUF_DEPTH];
    logic [BUF_PTR_BITS-1:0] head_q;
    logic [BUF_PTR_BITS-1:0] head_d;
    logic [BUF_CNT_BITS-1:0] cnt_q;
    logic [BUF_CNT_BITS-1:0] cnt_d;
    logic                    do_push;
    logic                    do_pop;
    logic [BUF_PTR_BITS-1:0] wr_slot;

    // Next-state for entries, head and count; clear discards all contents.
    always_comb begin
        entry_d = entry_q;
        head_d  = head_q;
        cnt_d   = cnt_q;
        do_push = push & (cnt_q != BUF_FULL);
        do_pop  = pop & (cnt_q != '0);
        wr_slot = buf_slot(head_q, cnt_q);

        if (clear) begin
            cnt_d = '0;
        end else begin
            if (do_push) begin
                entry_d[wr_slot] = push_data;
            end
            if (do_pop) begin
                head_d = head_q + BUF_PTR_BITS'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt_d = cnt_q + BUF_CNT_BITS'(1);
                2'b01:   cnt_d = cnt_q - BUF_CNT_BITS'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Buffer state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
                entry_q[i] <= '0;
            end
            head_q <= '0;
            cnt_q  <= '0;
        end else begin
            entry_q <= entry_d;
            head_q  <= head_d;
            cnt_q   <= cnt_d;
        end
    end

    assign head_data = entry_q[head_q];
    assign cnt       = cnt_q;

endmodule

// File: rtl/async_fifo_stream_reader.sv
// Read-domain consumer for the async FIFO: pops the show-ahead port into a
// two-entry buffer, presents a valid/ready stream with frame delimiting and
// supports a flush that discards buffered and queued words.
module async_fifo_stream_reader
    import async_fifo_pkg::*;
#(
    parameter int unsigned DATA_BITS = 10,
    parameter int unsigned FRAME_LEN = 4,
    parameter int unsigned CNT_BIT   = $clog2(FRAME_LEN) + 1
) (
    input  logic                 r_clk,
    input  logic                 r_reset,
    input  logic [DATA_BITS-1:0] fifo_data,
    input  logic                 fifo_empty,
    output logic                 fifo_read,
    output logic [DATA_BITS-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 m_last,
    input  logic                 flush,
    output logic                 flush_busy,
    output logic [CNT_BIT-1:0]   frame_idx
);

    localparam logic [CNT_BIT-1:0] LAST_IDX = CNT_BIT'(FRAME_LEN - 1);

    rd_state_t               state_q;
    rd_state_t               state_d;
    logic [CNT_BIT-1:0]      frame_idx_q;
    logic [CNT_BIT-1:0]      frame_idx_d;
    logic                    buf_clear;
    logic                    buf_push;
    logic                    buf_pop;
    logic [BUF_CNT_BITS-1:0] buf_cnt;
    logic [DATA_BITS-1:0]    buf_head;

    stream_skid_buf2 #(
        .DATA_BITS (DATA_BITS)
    ) u_buf (
        .clk       (r_clk),
        .rst_n     (r_reset),
        .clear     (buf_clear),
        .push      (buf_push),
        .push_data (fifo_data),
        .pop       (buf_pop),
        .head_data (buf_head),
        .cnt       (buf_cnt)
    );

    // Next state, FIFO pop gating, buffer control and frame position.
    // fifo_read depends only on registered occupancy, never on m_ready; it is
    // also held low during reset so no FIFO word is lost while the buffer is
    // being cleared.
    always_comb begin
        state_d     = state_q;
        frame_idx_d = frame_idx_q;
        fifo_read   = 1'b0;
        m_valid     = 1'b0;
        buf_clear   = 1'b0;
        buf_push    = 1'b0;
        buf_pop     = 1'b0;

        case (state_q)
            RUN: begin
                m_valid   = (buf_cnt != '0);
                fifo_read = r_reset & ~fifo_empty & (buf_cnt < BUF_FULL);
                if (flush) begin
                    // Anything popped or handed out on this edge is discarded.
                    state_d     = FLUSH;
                    buf_clear   = 1'b1;
                    frame_idx_d = '0;
                end else begin
                    buf_push = fifo_read;
                    buf_pop  = m_valid & m_ready;
                    if (buf_pop) begin
                        frame_idx_d = (frame_idx_q == LAST_IDX) ? '0
                                    : frame_idx_q + CNT_BIT'(1);
                    end
                end
            end
            FLUSH: begin
                fifo_read = r_reset & ~fifo_empty;
                if (fifo_empty) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase

        m_last     = m_valid & (frame_idx_q == LAST_IDX);
        flush_busy = (state_q == FLUSH);
    end

    // Controller state and frame index registers.
    always_ff @(posedge r_clk or negedge r_reset) begin
        if (!r_reset) begin
            state_q     <= RUN;
            frame_idx_q <= '0;
        end else begin
            state_q     <= state_d;
            frame_idx_q <= frame_idx_d;
        end
    end

    assign m_data    = buf_head;
    assign frame_idx = frame_idx_q;

endmodule

// File: tb/tb_async_fifo_stream_reader.sv
// Directed + random bench for async_fifo_stream_reader against a queue-based
// reference of the stream behaviour.
module tb_async_fifo_stream_reader;

    localparam int DW = 10;
    localparam int FL = 4;
    localparam int CB = $clog2(FL) + 1;

    logic          r_clk = 1'b0;
    logic          r_reset;
    logic [DW-1:0] fifo_data;
    logic          fifo_empty;
    logic          fifo_read;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_last;
    logic          flush;
    logic          flush_busy;
    logic [CB-1:0] frame_idx;

    async_fifo_stream_reader #(
        .DATA_BITS (DW),
        .FRAME_LEN (FL),
        .CNT_BIT   (CB)
    ) dut (
        .r_clk      (r_clk),
        .r_reset    (r_reset),
        .fifo_data  (fifo_data),
        .fifo_empty (fifo_empty),
        .fifo_read  (fifo_read),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_last     (m_last),
        .flush      (flush),
        .flush_busy (flush_busy),
        .frame_idx  (frame_idx)
    );

    always #5 r_clk = ~r_clk;

    // FIFO contents (source) and words taken from the FIFO but not yet
    // handed to the sink (reference of the reader's buffer).
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] tr_q[$];
    int            fidx;
    bit            in_flush;
    int            hs_total;
    logic [DW-1:0] last_word;
    int            cyc_no;
    int            first_hs;
    int            last_hs;
    int            n_assert;
    int            n_fail;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [DW-1:0] w);
        fifo_q.push_back(w);
    endtask

    // Registered-style FIFO outputs, refreshed just after each active edge.
    task automatic drive_fifo();
        fifo_empty = (fifo_q.size() == 0);
        fifo_data  = (fifo_q.size() == 0) ? '1 : fifo_q[0];
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_fifo_read"}, 32'(fifo_read), 32'd0);
        chk({tag, "_m_valid"}, 32'(m_valid), 32'd0);
        chk({tag, "_m_last"}, 32'(m_last), 32'd0);
        chk({tag, "_flush_busy"}, 32'(flush_busy), 32'd0);
        chk({tag, "_m_data"}, 32'(m_data), 32'd0);
        chk({tag, "_frame_idx"}, 32'(frame_idx), 32'd0);
    endtask

    task automatic check_cycle(output bit exp_rd, output bit exp_valid);
        bit exp_last;
        exp_rd    = r_reset && !fifo_empty && (in_flush || tr_q.size() < 2);
        exp_valid = r_reset && !in_flush && (tr_q.size() > 0);
        exp_last  = exp_valid && (fidx == FL - 1);
        chk("fifo_read", 32'(fifo_read), 32'(exp_rd));
        chk("read_while_empty", 32'(fifo_read & fifo_empty), 32'd0);
        chk("m_valid", 32'(m_valid), 32'(exp_valid));
        chk("m_last", 32'(m_last), 32'(exp_last));
        chk("flush_busy", 32'(flush_busy), 32'(r_reset && in_flush));
        chk("frame_idx", 32'(frame_idx), 32'(fidx));
        if (exp_valid) begin
            chk("m_data", 32'(m_data), 32'(tr_q[0]));
        end
    endtask

    task automatic model_update(input bit exp_rd, input bit exp_valid, input bit rdy,
                                input bit fl, input bit emp, input bit rd_act);
        logic [DW-1:0] word;
        word = (fifo_q.size() > 0) ? fifo_q[0] : '0;
        if (fl && !in_flush) begin
            tr_q.delete();
            fidx     = 0;
            in_flush = 1'b1;
        end else if (in_flush) begin
            if (emp) in_flush = 1'b0;
        end else begin
            if (exp_valid && rdy) begin
                last_word = tr_q.pop_front();
                hs_total++;
                fidx = (fidx + 1) % FL;
                if (first_hs < 0) first_hs = cyc_no;
                last_hs = cyc_no;
            end
            if (exp_rd) tr_q.push_back(word);
        end
        if (rd_act && fifo_q.size() > 0) fifo_q.delete(0);
    endtask

    // One clock cycle: called at a falling edge, returns at the next one.
    task automatic cyc(input bit rdy, input bit fl);
        bit erd;
        bit ev;
        bit rd_act;
        bit emp;
        m_ready = rdy;
        flush   = fl;
        #1;
        check_cycle(erd, ev);
        rd_act = fifo_read;
        emp    = fifo_empty;
        @(posedge r_clk);
        model_update(erd, ev, rdy, fl, emp, rd_act);
        cyc_no++;
        #1;
        drive_fifo();
        @(negedge r_clk);
        flush = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((fifo_q.size() != 0 || tr_q.size() != 0 || in_flush || !fifo_empty) && n < 200) begin
            cyc(1'b1, 1'b0);
            n++;
        end
        chk(tag, 32'(n < 200), 32'd1);
    endtask

    initial begin
        int base;
        int n;
        logic [DW-1:0] exp_head;

        n_assert = 0; n_fail = 0; hs_total = 0; fidx = 0; in_flush = 1'b0;
        cyc_no = 0; first_hs = -1; last_hs = -1; last_word = '0;
        r_reset = 1'b0; flush = 1'b0; m_ready = 1'b0;
        fifo_empty = 1'b1; fifo_data = '1;

        // Reset values, then 10 idle cycles with an empty FIFO.
        repeat (2) @(negedge r_clk);
        chk_reset_outputs("rst");
        r_reset = 1'b1;
        repeat (10) cyc(1'b1, 1'b0);

        // Back-to-back streaming of 8 words with ready held high.
        for (int i = 1; i <= 8; i++) wr(DW'(i));
        base = hs_total; first_hs = -1;
        drain("t2_timeout");
        chk("t2_count", 32'(hs_total - base), 32'd8);
        chk("t2_span", 32'(last_hs - first_hs), 32'd7);
        chk("t2_last_word", 32'(last_word), 32'h008);

        // Sink stalled for 5 cycles: buffer fills, FIFO reads stop, head holds.
        for (int i = 1; i <= 8; i++) wr(DW'(i));
        repeat (5) cyc(1'b0, 1'b0);
        chk("t3_held_data", 32'(m_data), 32'h001);
        chk("t3_fifo_left", 32'(fifo_q.size()), 32'd6);
        base = hs_total;
        drain("t3_timeout");
        chk("t3_count", 32'(hs_total - base), 32'd8);

        // Ready toggling every cycle.
        for (int i = 0; i < 6; i++) wr(DW'(12'h020 + i));
        base = hs_total;
        for (int i = 0; i < 24; i++) cyc(1'(i % 2 == 0), 1'b0);
        chk("t4_count", 32'(hs_total - base), 32'd6);

        // Flush with 2 words buffered and 5 still in the FIFO.
        for (int i = 0; i < 7; i++) wr(DW'(12'h040 + i));
        repeat (6) cyc(1'b0, 1'b0);
        chk("t5_fifo_left", 32'(fifo_q.size()), 32'd5);
        base = hs_total;
        cyc(1'b1, 1'b1);
        n = 0;
        while (in_flush && n < 50) begin
            cyc(1'b1, (n == 1));
            n++;
        end
        chk("t5_flush_timeout", 32'(n < 50), 32'd1);
        chk("t5_dropped", 32'(fifo_q.size()), 32'd0);
        chk("t5_no_handshake", 32'(hs_total - base), 32'd0);
        wr(DW'(12'h0AA));
        drain("t5_post_timeout");
        chk("t5_first_after", 32'(last_word), 32'h0AA);
        chk("t5_count_after", 32'(hs_total - base), 32'd1);

        // Reset mid-frame with the buffer full; FIFO contents must survive.
        cyc(1'b1, 1'b1);
        drain("t6_align_timeout");
        for (int i = 1; i <= 8; i++) wr(DW'(12'h100 + i));
        base = hs_total; n = 0;
        while (hs_total - base < 2 && n < 40) begin
            cyc(1'b1, 1'b0);
            n++;
        end
        chk("t6_stream_timeout", 32'(n < 40), 32'd1);
        repeat (3) cyc(1'b0, 1'b0);
        chk("t6_pre_fidx", 32'(frame_idx), 32'd2);
        chk("t6_pre_valid", 32'(m_valid), 32'd1);
        exp_head = fifo_q[0];
        #2 r_reset = 1'b0;
        #1;
        chk_reset_outputs("t6_async");
        tr_q.delete(); fidx = 0; in_flush = 1'b0;
        @(negedge r_clk);
        r_reset = 1'b1;
        base = hs_total; n = 0;
        while (hs_total == base && n < 40) begin
            cyc(1'b1, 1'b0);
            n++;
        end
        chk("t6_resume_timeout", 32'(n < 40), 32'd1);
        chk("t6_resume_word", 32'(last_word), 32'(exp_head));
        drain("t6_drain_timeout");

        // Random writes, ready and occasional flush pulses.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0) wr(DW'($urandom));
            cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 49) == 0));
        end
        drain("rand_drain_timeout");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/async_fifo_stream_reader.md
Name: async_fifo_stream_reader

Overview:
- Read-side consumer for the team's asynchronous FIFO; lives entirely in the FIFO read clock domain.
- Pops words from the FIFO's show-ahead read port (data valid whenever empty is low; pop advances on the next edge) and re-presents them as a valid/ready stream.
- Uses a 2-entry output buffer so the FIFO read strobe never depends combinationally on downstream ready.
- Adds frame delimiting (last flag every FRAME_LEN words) and a flush mode that discards buffered and queued data.

Parameters:
- DATA_BITS, 10, width of FIFO words and stream data.
- FRAME_LEN, 4, words per frame; m_last is asserted on word FRAME_LEN-1; legal range ≥1.
- CNT_BIT, $clog2(FRAME_LEN)+1, width of frame index counter.

Ports:
- r_clk  in  1  read-domain clock; all logic is on its rising edge.
- r_reset  in  1  asynchronous active-low reset.
- fifo_data  in  DATA_BITS  FIFO output_data; valid when fifo_empty=0.
- fifo_empty  in  1  FIFO empty flag (registered in the FIFO, r_clk domain).
- fifo_read  out  1  pop strobe to the FIFO.
- m_data  out  DATA_BITS  stream data (buffer head).
- m_valid  out  1  stream valid.
- m_ready  in  1  stream ready from the sink.
- m_last  out  1  high with the word whose frame index is FRAME_LEN-1.
- flush  in  1  single-cycle pulse requesting a discard of all data.
- flush_busy  out  1  high while in FLUSH.
- frame_idx  out  CNT_BIT  index of the current head word within its frame.

Behaviour:
- Reset (r_reset=0, asynchronous):
  - cnt=0, both buffer entries invalid, frame_idx=0, state=RUN.
  - Outputs: fifo_read=0, m_valid=0, m_last=0, flush_busy=0, m_data=0.
- Buffer:
  - 2-entry circular register buffer with head pointer and cnt (0..2).
  - m_valid = (cnt≠0) and state=RUN; m_data = entry[head]. Both are registered-state outputs with no combinational path from m_ready.
- Pop rule in RUN:
  - fifo_read = ~fifo_empty & (cnt<2).
  - On each edge with fifo_read=1, fifo_data is written into entry[(head+cnt) mod 2].
  - Latency from fifo_empty falling to m_valid rising is 1 cycle.
- Occupancy:
  - pop = m_valid & m_ready; push = fifo_read.
  - cnt_next = cnt + push − pop.
  - Push and pop in the same cycle are legal at cnt=1 and keep cnt=1, giving 1 word/cycle steady state.
  - At cnt=2 there is no push; a pop drops cnt to 1, and the next cycle may push.
- Frame counter:
  - Increments on each pop; wraps to 0 after the pop of word FRAME_LEN-1.
  - m_last = m_valid & (frame_idx==FRAME_LEN-1).
  - FRAME_LEN=1 makes every word last.
- Hold rule: m_data and m_last stay stable while m_valid=1 and m_ready=0.
- State machine: RUN, FLUSH.
  - RUN→FLUSH: on flush=1. On that same edge, cnt←0 and frame_idx←0; any pop or push in that cycle is discarded.
  - In FLUSH:
    - m_valid=0 and flush_busy=1.
    - fifo_read = ~fifo_empty; popped words are dropped.
  - FLUSH→RUN: on the first edge where fifo_empty=1 is sampled. The first RUN cycle may pop normally.
  - flush=1 while already in FLUSH is ignored; the block stays in FLUSH.
- FIFO protocol:
  - fifo_read is never asserted while fifo_empty=1.
  - The block makes no assumption about how long empty takes to fall after the write side has written (synchronizer delay is 2–3 r_clk cycles).
- Reset mid-frame: buffered words and the frame position are lost; the FIFO contents are untouched.

Decomposition:
- Shared package async_fifo_pkg:
  - typedef rd_state_t {RUN, FLUSH}.
  - localparam for the buffer depth (2).
- Natural sub-module: stream_skid_buf2, containing the 2-entry buffer, head pointer, cnt and the push/pop logic.
- The top level holds the FSM, the frame counter and the fifo_read gating.

Test Plan:
1. Reset release with fifo_empty=1 → fifo_read=0, m_valid=0, frame_idx=0 for 10 cycles.
2. FIFO holds 0x001..0x008, m_ready=1 constant, FRAME_LEN=4 → m_data sequence 0x001..0x008 on 8 consecutive cycles after a 1-cycle latency; m_last with 0x004 and 0x008.
3. Same data, m_ready=0 for 5 cycles → cnt saturates at 2 after 2 pops, fifo_read=0 thereafter, m_data=0x001 held. Releasing m_ready gives 0x001, 0x002, 0x003 in order with no loss.
4. m_ready toggled 1/0 every cycle with 6 words → exactly 6 handshakes, order preserved, fifo_read never high while fifo_empty=1.
5. Flush pulse with 2 words buffered and 5 in the FIFO → flush_busy high while the 5 FIFO words are popped and dropped, m_valid=0 throughout, return to RUN when fifo_empty=1; next written word 0x0AA is emitted with frame_idx=0.
6. Assert r_reset low mid-frame (frame_idx=2, cnt=2) asynchronously between edges → all outputs go to reset values immediately; after release, streaming resumes from the FIFO head with frame_idx=0.
